// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle control FSM for the shared CPU datapath.
// Each instruction moves through fetch, decode, execute, memory and write-back
// states. Memory states wait on mem_ready, and a bounded wait counter limits how
// long they wait.
// Optional feature: define MCU_JUMP_EN to add the j instruction (JUMP state).
module multicycle_control_unit #(
    parameter int unsigned ALU_OP_W   = 3,
    parameter int unsigned WAIT_CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                retire,
    output logic                illegal,
    output logic                timeout,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecAddr = 4'd3,
        StMemRd    = 4'd4,
        StMemWr    = 4'd5,
        StWbR      = 4'd6,
        StWbMem    = 4'd7,
        StBranch   = 4'd8,
        StLuiWb    = 4'd9,
        StJump     = 4'd10,
        StErr      = 4'd15
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpLui   = 6'b001111;
`ifdef MCU_JUMP_EN
    localparam logic [5:0] OpJ     = 6'b000010;
`endif

    localparam logic [ALU_OP_W-1:0] AluAdd = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] AluSub = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] AluAnd = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] AluOr  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] AluXor = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] AluLui = ALU_OP_W'(5);

    // A wait expires on its (2^WAIT_CNT_W - 1)th stalled cycle, i.e. when the
    // counter would step to all-ones.
    localparam logic [WAIT_CNT_W-1:0] WaitLast = WAIT_CNT_W'((1 << WAIT_CNT_W) - 2);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    illegal_q, illegal_d;
    logic                    timeout_q, timeout_d;
    logic                    wait_state;
    logic                    r_func_ok;
    logic [ALU_OP_W-1:0]     r_alu_op;

    // Decode the R-type funct field into a legality flag and an ALU operation.
    always_comb begin
        r_func_ok = 1'b1;
        r_alu_op  = AluAdd;
        case (func)
            6'b100000: r_alu_op = AluAdd;
            6'b100010: r_alu_op = AluSub;
            6'b100100: r_alu_op = AluAnd;
            6'b100101: r_alu_op = AluOr;
            6'b100110: r_alu_op = AluXor;
            default:   r_func_ok = 1'b0;
        endcase
    end

    // Next state, sticky flags, wait counter, and per-state datapath controls.
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        wait_state = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = AluAdd;
        retire     = 1'b0;
        case (state_q)
            StFetch: begin
                wait_state = 1'b1;
                mem_req    = 1'b1;
                alu_src_b  = 2'b01;
                // mem_ready is ignored while reset is held
                ir_write   = mem_ready & rst_n;
                pc_write   = mem_ready & rst_n;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (op)
                    OpRType: state_d = r_func_ok ? StExecR : StErr;
                    OpLw, OpSw: state_d = StExecAddr;
                    OpBeq:   state_d = StBranch;
                    OpLui:   state_d = StLuiWb;
`ifdef MCU_JUMP_EN
                    OpJ:     state_d = StJump;
`endif
                    default: state_d = StErr;
                endcase
                if (state_d == StErr) illegal_d = 1'b1;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op;
                state_d   = StWbR;
            end
            StWbR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StExecAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                wait_state = 1'b1;
                mem_req    = 1'b1;
                i_or_d     = 1'b1;
                if (mem_ready) state_d = StWbMem;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                wait_state = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                i_or_d     = 1'b1;
                retire     = mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_src    = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StLuiWb: begin
                alu_src_b = 2'b10;
                alu_op    = AluLui;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
`ifdef MCU_JUMP_EN
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
            end
`endif
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase

        // Stalled cycles count up; any other cycle clears, so every wait starts at 0.
        // mem_ready on the expiry cycle completes the transfer normally.
        wait_cnt_d = '0;
        if (wait_state && !mem_ready) begin
            if (wait_cnt_q == WaitLast) begin
                state_d   = StErr;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
            end
        end
    end

    // State, wait counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random and directed instruction streams for
// multicycle_control_unit, checked every cycle against a sequence-list model.
module tb_multicycle_control_unit;

    localparam int WaitW = 4;
    localparam int Tmo   = (1 << WaitW) - 1;
`ifdef MCU_JUMP_EN
    localparam bit JumpEn = 1'b1;
`else
    localparam bit JumpEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, func;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [2:0] alu_op;
    logic       retire, illegal, timeout;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_OP_W(3), .WAIT_CNT_W(WaitW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .retire(retire), .illegal(illegal), .timeout(timeout), .state(state)
    );

    int checks = 0;
    int errors = 0;

    // Model: each instruction is a list of states; memory states repeat while stalled.
    int  m_seq[8];
    int  m_len;
    int  m_pos;
    int  m_stalls;
    bit  m_err;
    bit  m_illegal;
    bit  m_timeout;

    logic [22:0] exp_vec;
    logic [22:0] act_vec;
    bit          check_en = 1'b0;
    logic        seen_retire, seen_pc_write;
    logic [1:0]  seen_pc_src;
    logic [2:0]  seen_alu_op;
    logic [3:0]  seen_state;

    assign act_vec = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, retire,
                      illegal, timeout, state};

    function automatic bit is_rfunc(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b100110;
    endfunction

    function automatic logic [2:0] alu_of_func(input logic [5:0] f);
        case (f)
            6'b100010: return 3'd1;
            6'b100100: return 3'd2;
            6'b100101: return 3'd3;
            6'b100110: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic int cur_state();
        return m_err ? 15 : m_seq[m_pos];
    endfunction

    // Control outputs the datapath needs in a given state.
    function automatic logic [22:0] expect_vec(input int st, input bit rdy, input bit z,
                                               input logic [5:0] f, input bit in_rst);
        logic mreq, mwe, iod, irw, pcw, rw, rd, m2r, sa, ret;
        logic [1:0] psrc, sb;
        logic [2:0] aop;
        mreq = 0; mwe = 0; iod = 0; irw = 0; pcw = 0; rw = 0; rd = 0; m2r = 0;
        sa = 0; ret = 0; psrc = 2'b00; sb = 2'b00; aop = 3'd0;
        case (st)
            0:  begin mreq = 1; sb = 2'b01; irw = rdy && !in_rst; pcw = rdy && !in_rst; end
            1:  sb = 2'b11;
            2:  begin sa = 1; aop = alu_of_func(f); end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mreq = 1; iod = 1; end
            5:  begin mreq = 1; mwe = 1; iod = 1; ret = rdy; end
            6:  begin rw = 1; rd = 1; ret = 1; end
            7:  begin rw = 1; m2r = 1; ret = 1; end
            8:  begin sa = 1; aop = 3'd1; psrc = 2'b01; pcw = z; ret = 1; end
            9:  begin sb = 2'b10; aop = 3'd5; rw = 1; ret = 1; end
            10: begin psrc = 2'b10; pcw = 1; ret = 1; end
            default: ;
        endcase
        return {mreq, mwe, iod, irw, pcw, psrc, rw, rd, m2r, sa, sb, aop, ret,
                m_illegal, m_timeout, 4'(st)};
    endfunction

    // Build the state list of the instruction now in the IR.
    task automatic plan(input logic [5:0] o, input logic [5:0] f);
        m_seq[0] = 0;
        m_seq[1] = 1;
        if (o == 6'b000000 && is_rfunc(f)) begin
            m_seq[2] = 2; m_seq[3] = 6; m_len = 4;
        end else if (o == 6'b100011) begin
            m_seq[2] = 3; m_seq[3] = 4; m_seq[4] = 7; m_len = 5;
        end else if (o == 6'b101011) begin
            m_seq[2] = 3; m_seq[3] = 5; m_len = 4;
        end else if (o == 6'b000100) begin
            m_seq[2] = 8; m_len = 3;
        end else if (o == 6'b001111) begin
            m_seq[2] = 9; m_len = 3;
        end else if (o == 6'b000010 && JumpEn) begin
            m_seq[2] = 10; m_len = 3;
        end else begin
            m_seq[2] = 15; m_len = 3;
        end
    endtask

    task automatic model_reset();
        m_seq[0] = 0; m_len = 1; m_pos = 0; m_stalls = 0;
        m_err = 0; m_illegal = 0; m_timeout = 0;
    endtask

    task automatic advance(input bit rdy);
        int st;
        if (m_err) return;
        st = m_seq[m_pos];
        if ((st == 0 || st == 4 || st == 5) && !rdy) begin
            if (m_stalls + 1 == Tmo) begin
                m_err = 1; m_timeout = 1;
            end else begin
                m_stalls++;
            end
            return;
        end
        m_stalls = 0;
        if (st == 0) plan(op, func);
        m_pos++;
        if (m_pos >= m_len) begin
            m_pos = 0;
        end else if (m_seq[m_pos] == 15) begin
            m_err = 1; m_illegal = 1;
        end
    endtask

    // One clock cycle: drive inputs, publish expectation, step the model.
    task automatic cycle(input bit rdy, input bit z);
        mem_ready = rdy;
        zero      = z;
        exp_vec   = expect_vec(cur_state(), rdy, z, func, !rst_n);
        check_en  = 1'b1;
        @(negedge clk);
        seen_retire   = retire;
        seen_pc_write = pc_write;
        seen_pc_src   = pc_src;
        seen_alu_op   = alu_op;
        seen_state    = state;
        @(posedge clk);
        if (rst_n) advance(rdy);
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL cycle t=%0t state %0d: got %h want %h", $time,
                         cur_state(), act_vec, exp_vec);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        cycle(1, 0);
        cycle(1, 0);
        rst_n = 1'b1;
    endtask

    // Run one instruction with zero-wait fetch; returns cycles up to its retire.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                             input int data_stalls, output int cyc);
        int ds;
        bit r;
        ds  = 0;
        cyc = 0;
        op  = o;
        func = f;
        for (int k = 0; k < 40; k++) begin
            r = 1'b1;
            if ((cur_state() == 4 || cur_state() == 5) && ds < data_stalls) begin
                r = 1'b0;
                ds++;
            end
            cycle(r, z);
            cyc++;
            if (seen_retire === 1'b1 || m_err) break;
        end
    endtask

    initial begin
        int cyc, rets, sel, mode;
        bit r, started;
        logic [5:0] o, f;
        rst_n = 1'b1; op = '0; func = '0; zero = 0; mem_ready = 0;
        #2;
        apply_reset();
        check("reset_state", int'(state), 0);

        run_instr(6'b000000, 6'b100000, 0, 0, cyc);
        check("add_cycles", cyc, 4);
        check("add_retire_state", int'(seen_state), 6);
        run_instr(6'b100011, 6'b000000, 0, 3, cyc);
        check("lw_cycles", cyc, 8);
        check("lw_timeout", int'(timeout), 0);
        run_instr(6'b101011, 6'b111111, 0, 0, cyc);
        check("sw_cycles", cyc, 4);
        run_instr(6'b000100, 6'b010101, 1, 0, cyc);
        check("beq_taken_cycles", cyc, 3);
        check("beq_taken_pcw", int'(seen_pc_write), 1);
        check("beq_pc_src", int'(seen_pc_src), 1);
        run_instr(6'b000100, 6'b010101, 0, 0, cyc);
        check("beq_not_taken_pcw", int'(seen_pc_write), 0);
        run_instr(6'b001111, 6'bxxxxxx, 0, 0, cyc);
        check("lui_cycles", cyc, 3);
        check("lui_alu_op", int'(seen_alu_op), 5);

        run_instr(6'b111111, 6'b000000, 0, 0, cyc);
        rets = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0);
            if (seen_retire === 1'b1) rets++;
        end
        check("illegal_state", int'(state), 15);
        check("illegal_sticky", int'(illegal), 1);
        check("illegal_no_retire", rets, 0);
        apply_reset();
        run_instr(6'b000010, 6'b000000, 0, 0, cyc);
        if (JumpEn) check("jump_pc_src", int'(seen_pc_src), 2);
        else check("j_disabled_state", int'(state), 15);

        // Fetch never answered: expires after Tmo stalled cycles.
        apply_reset();
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0);
            cyc++;
            if (state == 4'd15) break;
        end
        check("timeout_cycles", cyc, 15);
        check("timeout_flag", int'(timeout), 1);

        // Ready on the expiry cycle completes the fetch.
        apply_reset();
        op = 6'b001111;
        for (int k = 0; k < Tmo - 1; k++) cycle(0, 0);
        cycle(1, 0);
        check("expiry_ready_state", int'(state), 1);
        check("expiry_ready_timeout", int'(timeout), 0);
        cycle(1, 0);

        // Asynchronous reset in the middle of a store wait.
        op = 6'b101011;
        func = 6'b000000;
        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
        cycle(0, 0);
        check("sw_wait_state", int'(state), 5);
        mem_ready = 0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_mem_we", int'(mem_we), 0);
        model_reset();
        cycle(1, 0);
        rst_n = 1'b1;

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            f = 6'($urandom_range(0, 63));
            case (sel)
                0, 1, 2: begin
                    o = 6'b000000;
                    case ($urandom_range(0, 4))
                        0: f = 6'b100000;
                        1: f = 6'b100010;
                        2: f = 6'b100100;
                        3: f = 6'b100101;
                        default: f = 6'b100110;
                    endcase
                end
                3: o = 6'b100011;
                4: o = 6'b101011;
                5: o = 6'b000100;
                6: o = 6'b001111;
                7: o = 6'b000010;
                8: begin o = 6'b000000; f = 6'b101010; end
                default: o = 6'($urandom_range(0, 63));
            endcase
            op = o;
            func = f;
            mode = $urandom_range(0, 15);
            started = 0;
            for (int k = 0; k < 100; k++) begin
                r = (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
                cycle(r, 1'($urandom_range(0, 1)));
                if (m_err) break;
                if (m_pos != 0) started = 1;
                else if (started) break;
            end
            if (m_err) begin
                cycle(1, 0);
                cycle(1, 0);
                apply_reset();
            end
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
